// File: rtl/click_burst_counter.sv
// click_burst_counter
//
// Groups single-cycle press strobes from the debouncer into bursts. Strobes
// that follow each other within WINDOW_CYCLES are counted together. A burst
// closes when the gap runs out or when it reaches MAX_CLICKS presses. The
// burst length is then offered as one event on a valid/ready output.
//
// Optional feature: define CLICK_BURST_DROP_COUNT_EN to add the drop_count
// output. It is a saturating count of strobes that arrive while an event is
// waiting and is not being accepted in that cycle.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   pulse_in     in   press strobe, one press per high cycle
//   event_valid  out  burst result available (registered)
//   event_count  out  presses in the burst, 1..MAX_CLICKS, stable while valid
//   event_ready  in   consumer accepts the event
//   busy         out  registered, high whenever the state is not idle
//   drop_count   out  8-bit saturating dropped-strobe count (optional)
module click_burst_counter #(
    parameter int unsigned WINDOW_CYCLES = 4096,
    parameter int unsigned MAX_CLICKS    = 3,
    parameter int unsigned COUNT_W       = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pulse_in,
    output logic               event_valid,
    output logic [COUNT_W-1:0] event_count,
    input  logic               event_ready,
    output logic               busy
`ifdef CLICK_BURST_DROP_COUNT_EN
    ,
    output logic [7:0]         drop_count
`endif
);

    localparam int unsigned TIMER_W = $clog2(WINDOW_CYCLES);

    // The strobe cycle itself is the first cycle of the gap. The timer reads 0
    // one cycle after the strobe, so the window ends when it reaches
    // WINDOW_CYCLES-2. The event then appears WINDOW_CYCLES cycles after the
    // cycle that carried the last strobe.
    localparam logic [TIMER_W-1:0] TimerLast = TIMER_W'(WINDOW_CYCLES - 2);
    localparam logic [COUNT_W-1:0] MaxCount  = COUNT_W'(MAX_CLICKS);
    localparam logic [COUNT_W-1:0] OneCount  = COUNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StPending
    } state_e;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               valid_q, busy_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;

        unique case (state_q)
            StIdle: begin
                if (pulse_in) begin
                    count_d = OneCount;
                    timer_d = '0;
                    state_d = (MAX_CLICKS == 1) ? StPending : StCollect;
                end
            end

            StCollect: begin
                // A strobe takes priority over a timeout in the same cycle.
                if (pulse_in) begin
                    count_d = count_q + OneCount;
                    timer_d = '0;
                    if (count_q + OneCount == MaxCount) begin
                        state_d = StPending;
                    end
                end else if (timer_q == TimerLast) begin
                    timer_d = '0;
                    state_d = StPending;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            StPending: begin
                // The count is held here. A strobe counts only if the event
                // is accepted in the same cycle, and then it starts a new burst.
                if (event_ready) begin
                    if (pulse_in) begin
                        count_d = OneCount;
                        timer_d = '0;
                        state_d = (MAX_CLICKS == 1) ? StPending : StCollect;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            timer_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            valid_q <= (state_d == StPending);
            busy_q  <= (state_d != StIdle);
        end
    end

    assign event_valid = valid_q;
    assign event_count = count_q;
    assign busy        = busy_q;

`ifdef CLICK_BURST_DROP_COUNT_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (state_q == StPending && pulse_in && !event_ready && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_click_burst_counter.sv
// Testbench for click_burst_counter with WINDOW_CYCLES=16 and MAX_CLICKS=3.
// The cycle convention follows the test plan. Inputs for cycle c are driven in
// the middle of cycle c and sampled at the edge that ends it. Outputs sampled
// in the middle of cycle c show the result of the previous edge.
module tb_click_burst_counter;

    localparam int W = 16;
    localparam int M = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pulse_in = 1'b0;
    logic       event_ready = 1'b1;
    logic       event_valid;
    logic       busy;
    logic [1:0] event_count;
`ifdef CLICK_BURST_DROP_COUNT_EN
    logic [7:0] drop_count;
`endif

    always #5 clk = ~clk;

    click_burst_counter #(
        .WINDOW_CYCLES(W),
        .MAX_CLICKS   (M),
        .COUNT_W      (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pulse_in   (pulse_in),
        .event_valid(event_valid),
        .event_count(event_count),
        .event_ready(event_ready),
        .busy       (busy)
`ifdef CLICK_BURST_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Behavioural model. A burst is tracked by the cycle of its last strobe,
    // and the gap is measured as the elapsed cycle count.
    bit m_open, m_pend;
    int m_clicks, m_last, m_pcount, m_drops;

    // Event log for table scenarios
    int  ev_cyc_q[$];
    int  ev_cnt_q[$];
    int  busy_cycles;
    bit  prev_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_open = 0; m_pend = 0; m_clicks = 0; m_last = 0; m_pcount = 0; m_drops = 0;
    endfunction

    function automatic void model_start(int e);
        m_clicks = 1;
        m_last   = e;
        if (M == 1) begin
            m_pend = 1; m_open = 0; m_pcount = 1;
        end else begin
            m_open = 1;
        end
    endfunction

    function automatic void model_step(bit p, bit r, int e);
        if (m_pend) begin
            if (r) begin
                m_pend = 0;
                if (p) model_start(e);
            end else if (p && m_drops < 255) begin
                m_drops++;
            end
        end else if (m_open) begin
            if (p) begin
                m_clicks++;
                m_last = e;
                if (m_clicks == M) begin
                    m_open = 0; m_pend = 1; m_pcount = m_clicks;
                end
            end else if (e - m_last == W - 1) begin
                m_open = 0; m_pend = 1; m_pcount = m_clicks;
            end
        end else if (p) begin
            model_start(e);
        end
    endfunction

    // Starts and ends at a negedge. Checks the outputs against the model,
    // drives this cycle's inputs, then advances the model on the edge.
    task automatic cycle(input bit p, input bit r);
        check("valid", event_valid, m_pend);
        check("busy", busy, m_open || m_pend);
        if (m_pend) check("count", event_count, m_pcount);
`ifdef CLICK_BURST_DROP_COUNT_EN
        check("drop_count", drop_count, m_drops);
`endif
        if (event_valid && !prev_valid) begin
            ev_cyc_q.push_back(cyc);
            ev_cnt_q.push_back(int'(event_count));
        end
        if (busy) busy_cycles++;
        prev_valid  = event_valid;
        pulse_in    = p;
        event_ready = r;
        @(posedge clk);
        if (rst_n) model_step(p, r, cyc);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pulse_in = 1'b0;
        event_ready = 1'b1;
        #1;
        check("rst_valid", event_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", event_count, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        prev_valid = 0;
        busy_cycles = 0;
        ev_cyc_q.delete();
        ev_cnt_q.delete();
    endtask

    typedef struct {
        int s[4];
        int n_ev;
        int ev_c[2];
        int ev_n[2];
        int busy_cyc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{s: '{10, -1, -1, -1}, n_ev: 1, ev_c: '{26, 0}, ev_n: '{1, 0}, busy_cyc: 16};
        vecs[1] = '{s: '{10, 20, -1, -1}, n_ev: 1, ev_c: '{36, 0}, ev_n: '{2, 0}, busy_cyc: 26};
        vecs[2] = '{s: '{10, 27, -1, -1}, n_ev: 2, ev_c: '{26, 43}, ev_n: '{1, 1}, busy_cyc: 32};
        vecs[3] = '{s: '{10, 12, 14, 16}, n_ev: 2, ev_c: '{15, 32}, ev_n: '{3, 1}, busy_cyc: 21};
        vecs[4] = '{s: '{10, 25, -1, -1}, n_ev: 1, ev_c: '{41, 0}, ev_n: '{2, 0}, busy_cyc: 31};

        // Table scenarios, with event_ready tied high
        foreach (vecs[v]) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                bit p;
                p = (c == vecs[v].s[0]) || (c == vecs[v].s[1]) ||
                    (c == vecs[v].s[2]) || (c == vecs[v].s[3]);
                cycle(p, 1'b1);
            end
            check($sformatf("v%0d_n_events", v), ev_cyc_q.size(), vecs[v].n_ev);
            check($sformatf("v%0d_busy_cycles", v), busy_cycles, vecs[v].busy_cyc);
            for (int i = 0; i < vecs[v].n_ev && i < ev_cyc_q.size(); i++) begin
                check($sformatf("v%0d_ev%0d_cycle", v, i), ev_cyc_q[i], vecs[v].ev_c[i]);
                check($sformatf("v%0d_ev%0d_count", v, i), ev_cnt_q[i], vecs[v].ev_n[i]);
            end
        end

        // Backpressure: valid is held, strobes 30 and 31 are dropped, ready at 40
        do_reset();
        for (int c = 0; c < 50; c++) begin
            if (c == 25) check("bp_valid_25", event_valid, 0);
            if (c == 26 || c == 40) begin
                check("bp_valid_held", event_valid, 1);
                check("bp_count_held", event_count, 1);
            end
            if (c == 41) begin
                check("bp_valid_41", event_valid, 0);
                check("bp_busy_41", busy, 0);
`ifdef CLICK_BURST_DROP_COUNT_EN
                check("bp_drop_count", drop_count, 2);
`endif
            end
            cycle((c == 10) || (c == 30) || (c == 31), c >= 40);
        end

        // Reset in the middle of a burst discards it
        do_reset();
        for (int c = 0; c < 15; c++) cycle((c == 10) || (c == 12), 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", event_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", event_count, 0);
        model_reset();
        #1;
        for (int c = 15; c < 17; c++) cycle(1'b0, 1'b1);
        rst_n = 1'b1;
        for (int c = 17; c < 60; c++) cycle(c == 30, 1'b1);
        check("mid_rst_n_events", ev_cyc_q.size(), 1);
        if (ev_cyc_q.size() >= 1) begin
            check("mid_rst_ev_cycle", ev_cyc_q[0], 46);
            check("mid_rst_ev_count", ev_cnt_q[0], 1);
        end

        // Random strobes and random backpressure against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bit p, r;
            p = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 3) != 0);
            cycle(p, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
